// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with a shared N-to-1 data mux feeding a one-entry
// registered output stage; every port is a valid/ready handshake.

module rr_mux_lane #(
    parameter int WIDTH = 8
) (
    input  logic             valid,
    input  logic             in_hi,
    input  logic             hi_pend,
    input  logic             lo_pend,
    input  logic             any_hi,
    input  logic [WIDTH-1:0] data,
    output logic             masked,
    output logic             grant,
    output logic [WIDTH-1:0] gated
);
    // Lanes at or above ptr win if no earlier lane in that upper window asks;
    // lanes below ptr only win when the upper window is entirely idle.
    assign masked = valid & in_hi;
    assign grant  = valid & (in_hi ? ~hi_pend : (~any_hi & ~lo_pend));
    assign gated  = grant ? data : '0;
endmodule

module rr_mux_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int SRC_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [SRC_W-1:0]       out_src,
    input  logic                   out_ready
);
    logic [SRC_W-1:0]              ptr;
    logic [N_REQ-1:0][WIDTH-1:0]   data_arr;
    logic [N_REQ-1:0][WIDTH-1:0]   gated;
    logic [N_REQ-1:0]              in_hi;
    logic [N_REQ-1:0]              masked;
    logic [N_REQ-1:0]              grant;
    logic [N_REQ:0]                hi_chain;
    logic [N_REQ-1:0]              lo_chain;
    logic [WIDTH-1:0]              sel_data;
    logic [SRC_W-1:0]              sel_idx;
    logic [SRC_W-1:0]              ptr_nxt;
    logic                          can_accept;
    logic                          xfer;

    assign data_arr    = req_data;
    assign hi_chain[0] = 1'b0;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign in_hi[i]       = (SRC_W'(i) >= ptr);
        assign hi_chain[i+1]  = hi_chain[i] | masked[i];
        if (i == 0) begin : g_lo0
            assign lo_chain[i] = 1'b0;
        end else begin : g_lon
            assign lo_chain[i] = lo_chain[i-1] | req_valid[i-1];
        end

        rr_mux_lane #(.WIDTH(WIDTH)) u_lane (
            .valid   (req_valid[i]),
            .in_hi   (in_hi[i]),
            .hi_pend (hi_chain[i]),
            .lo_pend (lo_chain[i]),
            .any_hi  (hi_chain[N_REQ]),
            .data    (data_arr[i]),
            .masked  (masked[i]),
            .grant   (grant[i]),
            .gated   (gated[i])
        );
    end

    // Grant is one-hot, so OR-reduction acts as the mux and the encoder.
    always_comb begin
        sel_data = '0;
        sel_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_data = sel_data | gated[i];
            if (grant[i]) sel_idx = sel_idx | SRC_W'(i);
        end
    end

    assign ptr_nxt    = (sel_idx == SRC_W'(N_REQ-1)) ? '0 : sel_idx + SRC_W'(1);
    assign can_accept = ~out_valid | out_ready;
    assign req_ready  = (rst || !can_accept) ? '0 : grant;
    assign xfer       = |req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= sel_idx;
            ptr       <= ptr_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed table-driven bench for rr_mux_arbiter (N_REQ=4, WIDTH=8).

module tb_rr_mux_arbiter;
    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int SRC_W = 2;
    localparam logic [31:0] D0 = 32'h13121110;
    localparam logic [31:0] D1 = 32'h13A51110;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [SRC_W-1:0]       out_src;
    logic                   out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic        ord;
        logic [31:0] data;
        logic [3:0]  rr;
        logic        ov;
        logic [7:0]  od;
        logic [1:0]  os;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    rr_mux_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    endtask

    function automatic void add(input logic r, input logic [3:0] rv, input logic ord,
                                input logic [31:0] d, input logic [3:0] rr,
                                input logic ov, input logic [7:0] od, input logic [1:0] os);
        vec_t v;
        v.rst = r; v.rv = rv; v.ord = ord; v.data = d;
        v.rr = rr; v.ov = ov; v.od = od; v.os = os;
        vecs.push_back(v);
    endfunction

    initial begin
        // rst rv ord data | req_ready out_valid out_data out_src (after edge)
        add(1, 4'b0000, 1, D0, 4'b0000, 0, 8'h00, 0);   // reset + idle
        add(1, 4'b0000, 1, D0, 4'b0000, 0, 8'h00, 0);
        add(0, 4'b0000, 1, D0, 4'b0000, 0, 8'h00, 0);
        add(0, 4'b0100, 1, D1, 4'b0100, 1, 8'hA5, 2);   // single requester, ptr->3
        add(0, 4'b0000, 1, D1, 4'b0000, 0, 8'hA5, 2);   // drain keeps data/src
        add(1, 4'b0000, 1, D0, 4'b0000, 0, 8'h00, 0);   // reset, ptr->0
        add(0, 4'b1111, 1, D0, 4'b0001, 1, 8'h10, 0);   // full contention
        add(0, 4'b1111, 1, D0, 4'b0010, 1, 8'h11, 1);
        add(0, 4'b1111, 1, D0, 4'b0100, 1, 8'h12, 2);
        add(0, 4'b1111, 1, D0, 4'b1000, 1, 8'h13, 3);
        add(0, 4'b1111, 1, D0, 4'b0001, 1, 8'h10, 0);
        add(0, 4'b1111, 1, D0, 4'b0010, 1, 8'h11, 1);   // ptr=2
        add(0, 4'b1111, 0, D0, 4'b0000, 1, 8'h11, 1);   // backpressure x3
        add(0, 4'b1111, 0, D0, 4'b0000, 1, 8'h11, 1);
        add(0, 4'b1111, 0, D0, 4'b0000, 1, 8'h11, 1);
        add(0, 4'b1111, 1, D0, 4'b0100, 1, 8'h12, 2);   // release: next in turn, ptr=3
        add(0, 4'b0011, 1, D0, 4'b0001, 1, 8'h10, 0);   // wrap and skip 3
        add(0, 4'b0011, 1, D0, 4'b0010, 1, 8'h11, 1);
        add(0, 4'b0011, 1, D0, 4'b0001, 1, 8'h10, 0);
        add(0, 4'b0011, 1, D0, 4'b0010, 1, 8'h11, 1);   // holding src 1
        add(1, 4'b1111, 0, D0, 4'b0000, 0, 8'h00, 0);   // reset mid-stream
        add(0, 4'b1111, 1, D0, 4'b0001, 1, 8'h10, 0);   // first grant to 0
        add(0, 4'b0000, 1, D0, 4'b0000, 0, 8'h10, 0);   // idle keeps ptr=1
        add(0, 4'b1111, 1, D0, 4'b0010, 1, 8'h11, 1);
        add(0, 4'b0000, 0, D0, 4'b0000, 1, 8'h11, 1);   // stall, nothing pending
        add(0, 4'b1000, 0, D0, 4'b0000, 1, 8'h11, 1);   // stall blocks request
        add(0, 4'b1000, 1, D0, 4'b1000, 1, 8'h13, 3);   // drain + accept
        add(0, 4'b0000, 0, D0, 4'b0000, 1, 8'h13, 3);
        add(0, 4'b0000, 1, D0, 4'b0000, 0, 8'h13, 3);   // drain
        add(0, 4'b0001, 0, D0, 4'b0001, 1, 8'h10, 0);   // empty accepts despite !out_ready

        foreach (vecs[k]) begin
            rst       = vecs[k].rst;
            req_valid = vecs[k].rv;
            out_ready = vecs[k].ord;
            req_data  = vecs[k].data;
            #1;
            check("req_ready", k, 32'(req_ready), 32'(vecs[k].rr));
            @(posedge clk);
            #1;
            check("out_valid", k, 32'(out_valid), 32'(vecs[k].ov));
            check("out_data",  k, 32'(out_data),  32'(vecs[k].od));
            check("out_src",   k, 32'(out_src),   32'(vecs[k].os));
        end

        // Sustained fairness after reset: one item per cycle, rotating 0..3.
        rst = 1'b1; req_valid = '0; out_ready = 1'b1; req_data = D0;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("fair_ready", 100 + k, 32'(req_ready), 32'(4'b0001 << (k % 4)));
            @(posedge clk); #1;
            check("fair_valid", 100 + k, 32'(out_valid), 32'd1);
            check("fair_src",   100 + k, 32'(out_src),   32'(k % 4));
            check("fair_data",  100 + k, 32'(out_data),  32'(8'h10 + k % 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
